// File: rtl/fp_pkg.sv
// Shared single-precision constants, field helpers and divider step-phase decode.
package fp_pkg;
  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int BIAS       = 127;
  localparam int FP_EXP_MAX = 255;
  localparam int DIV_STEPS  = 25;

  // Remainder carries hidden bit, one guard bit above and one below the mantissa.
  localparam int RW = MANT_W + 3;
  localparam int QW = DIV_STEPS;

  localparam logic [4:0] S_PACK = 5'(DIV_STEPS + 1);
  localparam logic [4:0] S_DONE = 5'(DIV_STEPS + 2);

  typedef enum logic [1:0] {PH_LOAD, PH_ITER, PH_PACK, PH_DONE} phase_e;

  function automatic logic fp_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [MANT_W-1:0] fp_mant(input logic [31:0] v);
    return v[22:0];
  endfunction

  // Any value with a cleared magnitude is zero, whatever its sign.
  function automatic logic fp_is_zero(input logic [31:0] v);
    return v[30:0] == 31'd0;
  endfunction

  function automatic phase_e phase_of(input logic [4:0] s);
    if (s == 5'd0)        return PH_LOAD;
    else if (s < S_PACK)  return PH_ITER;
    else if (s == S_PACK) return PH_PACK;
    else                  return PH_DONE;
  endfunction
endpackage

// File: rtl/fp_divider_if.sv
// CPU-side run/stall handshake of the FP divider.
interface fp_divider_if;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;

  modport master (output run, x, y, input stall, z);
  modport slave  (input run, x, y, output stall, z);
endinterface

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: one quotient bit per step, no rounding.
module fp_div_core
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [MANT_W-1:0] xm_i,
  input  logic [MANT_W-1:0] ym_i,
  output logic [QW-1:0]     q_o
);
  logic [RW-1:0] r_q, r_d;
  logic [QW-1:0] q_q, q_d;
  logic [RW-1:0] dvs;
  logic [RW:0]   diff;

  // Trial subtract and choose between restored or reduced remainder.
  always_comb begin
    dvs  = {2'b01, ym_i, 1'b0};
    diff = {1'b0, r_q} - {1'b0, dvs};
    r_d  = r_q;
    q_d  = q_q;
    if (load_i) begin
      r_d = {2'b01, xm_i, 1'b0};
      q_d = '0;
    end else if (step_i) begin
      if (!diff[RW]) begin
        r_d = {diff[RW-2:0], 1'b0};
        q_d = {q_q[QW-2:0], 1'b1};
      end else begin
        r_d = {r_q[RW-2:0], 1'b0};
        q_d = {q_q[QW-2:0], 1'b0};
      end
    end
  end

  // Remainder / quotient registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/fp_divider.sv
// Multi-cycle single-precision divider with run/stall handshake, truncating.
module fp_divider
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_divider_if.slave  bus
);
  localparam logic signed [9:0] EXP_HI = 10'(BIAS);
  localparam logic signed [9:0] EXP_LO = 10'(BIAS - 1);
  localparam logic signed [9:0] EXP_SAT = 10'(FP_EXP_MAX);

  logic [4:0]        s_q, s_d;
  logic              done_q, done_d;
  logic [31:0]       z_q, z_d;
  logic              sign_q, xz_q, yz_q;
  logic signed [9:0] exp_q;
  logic signed [9:0] exp_n;
  logic [MANT_W-1:0] mant_n;
  logic [QW-1:0]     q;
  phase_e            phase;
  logic              load, step, pack;

  fp_div_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .step_i (step),
    .xm_i   (fp_mant(bus.x)),
    .ym_i   (fp_mant(bus.y)),
    .q_o    (q)
  );

  // Step sequencing, done flag and the pack / special-case selection.
  always_comb begin
    phase  = phase_of(s_q);
    load   = bus.run && (phase == PH_LOAD);
    step   = bus.run && (phase == PH_ITER);
    pack   = bus.run && (phase == PH_PACK);
    s_d    = '0;
    done_d = 1'b0;
    if (bus.run) begin
      s_d    = (s_q == S_DONE) ? s_q : s_q + 5'd1;
      done_d = done_q | pack;
    end
    // Quotient lies in (0.5, 2): normalise on its integer bit.
    exp_n  = exp_q + (q[QW-1] ? EXP_HI : EXP_LO);
    mant_n = q[QW-1] ? q[QW-2:1] : q[QW-3:0];
    z_d    = z_q;
    if (pack) begin
      if (xz_q)                 z_d = 32'd0;
      else if (yz_q)            z_d = {sign_q, 8'hFF, 23'd0};
      else if (exp_n <= 10'sd0) z_d = 32'd0;
      else if (exp_n >= EXP_SAT) z_d = {sign_q, 8'hFF, 23'd0};
      else                      z_d = {sign_q, exp_n[EXP_W-1:0], mant_n};
    end
  end

  // Control state, operand attributes captured at load, packed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      done_q <= 1'b0;
      z_q    <= '0;
      sign_q <= 1'b0;
      xz_q   <= 1'b0;
      yz_q   <= 1'b0;
      exp_q  <= '0;
    end else begin
      s_q    <= s_d;
      done_q <= done_d;
      z_q    <= z_d;
      if (load) begin
        sign_q <= fp_sign(bus.x) ^ fp_sign(bus.y);
        xz_q   <= fp_is_zero(bus.x);
        yz_q   <= fp_is_zero(bus.y);
        exp_q  <= $signed({2'b00, fp_exp(bus.x)}) - $signed({2'b00, fp_exp(bus.y)});
      end
    end
  end

  assign bus.stall = bus.run & ~done_q;
  assign bus.z     = z_q;
endmodule
